// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes. Single-cycle ops plus a
// WIDTH-cycle shift-add unsigned multiply; flags are taken from the final result.
module alu_seq #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [SHW-1:0]   shamt_i,
    input  logic [3:0]       op_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       flag_o
);

    localparam int CW = SHW + 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_NEG = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_SRL = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_SLT = 4'd9;

    typedef enum logic {S_IDLE, S_MUL} state_e;

    state_e               state_q, state_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [3:0]           flag_q, flag_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;

    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c, alu_ov, alu_known;
    logic [3:0]           alu_flag;
    logic [2*WIDTH-1:0]   acc_step;
    logic [3:0]           mul_flag;

    assign in_ready_o  = (state_q == S_IDLE) && (!out_valid_q || out_ready_i);
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign flag_o      = flag_q;

    // Single-cycle datapath; undefined opcodes yield zero result and zero flags.
    always_comb begin
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_ov    = 1'b0;
        alu_known = 1'b1;
        case (op_i)
            OP_ADD: begin
                {alu_c, alu_res} = {1'b0, a_i} + {1'b0, b_i};
                alu_ov = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (alu_res[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_NEG: alu_res = ~b_i + WIDTH'(1);
            OP_AND: alu_res = a_i & b_i;
            OP_XOR: alu_res = a_i ^ b_i;
            OP_SUB: begin
                alu_res = a_i - b_i;
                alu_c   = (a_i >= b_i);
                alu_ov  = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (alu_res[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SRL: alu_res = a_i >> shamt_i;
            OP_SLL: alu_res = a_i << shamt_i;
            OP_SRA: alu_res = $unsigned($signed(a_i) >>> shamt_i);
            OP_SLT: alu_res = WIDTH'($signed(a_i) < $signed(b_i));
            default: alu_known = 1'b0;
        endcase
        alu_flag = alu_known ? {alu_ov, alu_res[WIDTH-1], (alu_res == '0), alu_c} : 4'b0000;
    end

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_flag = {1'b0, acc_step[WIDTH-1], (acc_step[WIDTH-1:0] == '0),
                       (acc_step[2*WIDTH-1:WIDTH] != '0)};

    // Next-state: a result load at the same edge as a drain keeps out_valid high.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flag_d      = flag_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                if (in_valid_i && in_ready_o) begin
                    if (op_i == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, a_i};
                        mplier_d = b_i;
                        acc_d    = '0;
                        cnt_d    = CW'(WIDTH);
                        state_d  = S_MUL;
                    end else begin
                        result_d    = alu_res;
                        flag_d      = alu_flag;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d    = acc_step[WIDTH-1:0];
                    flag_d      = mul_flag;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flag_q      <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flag_q      <= flag_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vectors with literal expectations plus a
// scoreboard fed by a behavioural model of the opcode rules.
module tb_alu_seq;

    localparam int W = 32;
    localparam longint MAXS = 2147483647;
    localparam longint MINS = -MAXS - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [4:0]    shamt;
    logic [3:0]    op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [3:0]    flag;

    typedef struct packed {
        logic [W-1:0] res;
        logic [3:0]   flag;
    } expT;

    expT expQ[$];
    int numChecks = 0;
    int numErrors = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b), .shamt_i(shamt), .op_i(op),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .result_o(result), .flag_o(flag)
    );

    always #5 clk = ~clk;

    // Opcode rules expressed with wide integer arithmetic.
    function automatic expT modelOp(input logic [3:0] o, input logic [W-1:0] x,
                                    input logic [W-1:0] y, input logic [4:0] sh);
        expT e;
        longint sx, sy, s;
        logic [63:0] p;
        logic c, ov;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        c = 1'b0;
        ov = 1'b0;
        e.res = '0;
        e.flag = '0;
        case (o)
            4'd0: begin
                s = sx + sy;
                e.res = x + y;
                c = ({32'd0, x} + {32'd0, y}) >= 64'h1_0000_0000;
                ov = (s > MAXS) || (s < MINS);
            end
            4'd1: e.res = 32'd0 - y;
            4'd2: e.res = x & y;
            4'd3: e.res = x ^ y;
            4'd4: begin
                s = sx - sy;
                e.res = x - y;
                c = (x >= y);
                ov = (s > MAXS) || (s < MINS);
            end
            4'd5: e.res = x >> sh;
            4'd6: e.res = x << sh;
            4'd7: e.res = (x >> sh) | (x[W-1] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            4'd8: begin
                p = {32'd0, x} * {32'd0, y};
                e.res = p[31:0];
                c = (p[63:32] != 0);
            end
            4'd9: e.res = (sx < sy) ? 32'd1 : 32'd0;
            default: e.res = '0;
        endcase
        if (o <= 4'd9) begin
            e.flag = {ov, e.res[W-1], (e.res == 0), c};
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numErrors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Scoreboard: model results queued at input handshakes, popped at output handshakes.
    logic heldValid = 1'b0;
    logic [W-1:0] heldRes;
    logic [3:0] heldFlag;
    always @(negedge clk) begin
        if (!rst_n) begin
            heldValid = 1'b0;
        end else begin
            if (heldValid) begin
                checkOutput("holdValid", 64'(out_valid), 64'd1);
                checkOutput("holdResult", 64'(result), 64'(heldRes));
                checkOutput("holdFlag", 64'(flag), 64'(heldFlag));
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedResult", 64'(result), 64'hDEAD_BEEF_DEAD_BEEF);
                end else begin
                    expT e;
                    e = expQ.pop_front();
                    checkOutput("sbResult", 64'(result), 64'(e.res));
                    checkOutput("sbFlag", 64'(flag), 64'(e.flag));
                end
            end
            heldValid = out_valid && !out_ready;
            heldRes = result;
            heldFlag = flag;
            if (in_valid && in_ready) begin
                expQ.push_back(modelOp(op, a, b, shamt));
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic [4:0] sh);
        bit accepted = 1'b0;
        op = o; a = x; b = y; shamt = sh;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            checkOutput("acceptTimeout", 64'd0, 64'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Issue one op and check the first valid output against literal values.
    task automatic runOne(input string name, input logic [3:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [4:0] sh,
                          input logic [W-1:0] expRes, input logic [3:0] expFlag,
                          input int expEdges);
        int edges = 0;
        bit seen = 1'b0;
        bit readySeen = 1'b0;
        applyStimulus(o, x, y, sh);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            if (in_ready) readySeen = 1'b1;
            edges++;
        end
        checkOutput({name, "Seen"}, 64'(seen), 64'd1);
        checkOutput({name, "Result"}, 64'(result), 64'(expRes));
        checkOutput({name, "Flag"}, 64'(flag), 64'(expFlag));
        checkOutput({name, "Latency"}, 64'(edges), 64'(expEdges));
        if (o == 4'd8) begin
            checkOutput({name, "BusyNoReady"}, 64'(readySeen), 64'd0);
        end
        @(posedge clk);
        #1;
    endtask

    logic [3:0]   tOp[11]  = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd15, 4'd4, 4'd0};
    logic [W-1:0] tA[11]   = '{32'h0, 32'h0000F0F0, 32'hA5A5A5A5, 32'h80000000, 32'h1,
                               32'h40000000, 32'h3, 32'h1234, 32'h1, 32'h80000000, 32'h80000000};
    logic [W-1:0] tB[11]   = '{32'h5, 32'h0000FF00, 32'hA5A5A5A5, 32'h0, 32'h0,
                               32'h0, 32'h80000000, 32'h5678, 32'h1, 32'h1, 32'h80000000};
    logic [4:0]   tSh[11]  = '{5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 5'd3, 5'd0, 5'd2, 5'd0, 5'd0, 5'd0};

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; shamt = '0; op = '0;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rstValid", 64'(out_valid), 64'd0);
        checkOutput("rstResult", 64'(result), 64'd0);
        checkOutput("rstFlag", 64'(flag), 64'd0);
        checkOutput("rstReady", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        runOne("addOvf", 4'd0, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 4'b1100, 0);
        runOne("addCarry", 4'd0, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 4'b0011, 0);
        runOne("subNeg", 4'd4, 32'd5, 32'd7, 5'd0, 32'hFFFFFFFE, 4'b0100, 0);
        runOne("sltNeg", 4'd9, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, 4'b0000, 0);
        runOne("sraNeg", 4'd7, 32'h80000000, 32'h0, 5'd4, 32'hF8000000, 4'b0100, 0);
        runOne("mulWrap", 4'd8, 32'h10000, 32'h10000, 5'd0, 32'h0, 4'b0011, W);
        runOne("mulSmall", 4'd8, 32'd123, 32'd456, 5'd0, 32'd56088, 4'b0000, W);

        // Back-to-back single-cycle ops: one accepted every cycle.
        in_valid = 1'b1;
        for (int i = 0; i < 11; i++) begin
            op = tOp[i]; a = tA[i]; b = tB[i]; shamt = tSh[i];
            @(negedge clk);
            checkOutput("streamReady", 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: first result held, second op waits.
        out_ready = 1'b0;
        in_valid = 1'b1; op = 4'd0; a = 32'd1; b = 32'd2; shamt = '0;
        @(posedge clk);
        #1;
        a = 32'd10; b = 32'd20;
        repeat (4) begin
            @(negedge clk);
            checkOutput("bpReadyLow", 64'(in_ready), 64'd0);
            checkOutput("bpHeld", 64'(result), 64'd3);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bpReadyBack", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        a = 32'd100; b = 32'd200;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bpDrained", 64'(expQ.size()), 64'd0);

        // Reset in the middle of a multiply.
        applyStimulus(4'd8, 32'd3, 32'd5, 5'd0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midRstValid", 64'(out_valid), 64'd0);
        checkOutput("midRstResult", 64'(result), 64'd0);
        checkOutput("midRstFlag", 64'(flag), 64'd0);
        checkOutput("midRstReady", 64'(in_ready), 64'd1);
        expQ.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        begin
            bit sawValid = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (out_valid) sawValid = 1'b1;
            end
            checkOutput("midRstNoResult", 64'(sawValid), 64'd0);
        end

        checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", numChecks, numErrors);
        $finish;
    end

endmodule
